// File: rtl/instruction_memory_loader.sv
// Instruction store write-side loader: streams 32-bit words big-endian into a byte array, plus a word fetch port.
// Optional LOADER_CHECKSUM_EN adds a running 32-bit sum of accepted words on the checksum output.
module instruction_memory_loader #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [31:0]           load_base_adr,
    input  logic                  word_valid,
    input  logic [31:0]           word_data,
    input  logic                  word_last,
    output logic                  word_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] word_count,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]           checksum,
`endif
    input  logic [31:0]           pc,
    output logic [31:0]           instruction
);

    // state  | meaning
    // IDLE   | no session; waiting for load_start
    // ACCEPT | word_ready high, waiting for a valid word
    // WRITE  | emitting the latched word one byte per cycle, MSB first
    // DONE   | one-cycle done pulse after the last word's final byte
    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t                state;
    logic [7:0]            mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [1:0]            idx;
    logic [31:0]           data_q;
    logic                  last_q;
    logic [ADDR_WIDTH-1:0] wr_adr;
    logic [7:0]            wr_byte;
    logic [ADDR_WIDTH-1:0] fetch_adr;
    logic                  unused_addr_bits;

    assign wr_adr = wr_ptr + ADDR_WIDTH'(idx);

    always_comb begin
        wr_byte = data_q[31:24];
        case (idx)
            2'd0: wr_byte = data_q[31:24];
            2'd1: wr_byte = data_q[23:16];
            2'd2: wr_byte = data_q[15:8];
            2'd3: wr_byte = data_q[7:0];
            default: wr_byte = data_q[31:24];
        endcase
    end

    // Array has no reset so a loaded image survives rst; reset suppresses the write on its edge.
    always_ff @(posedge clk) begin
        if (!rst && state == WRITE) begin
            mem[wr_adr] <= wr_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            idx        <= 2'd0;
            wr_ptr     <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load_start) begin
                        state      <= ACCEPT;
                        wr_ptr     <= {load_base_adr[ADDR_WIDTH-1:2], 2'b00};
                        word_count <= '0;
                        word_ready <= 1'b1;
                        busy       <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        checksum   <= '0;
`endif
                    end
                end
                ACCEPT: begin
                    if (word_valid) begin
                        data_q     <= word_data;
                        last_q     <= word_last;
                        idx        <= 2'd0;
                        state      <= WRITE;
                        word_ready <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        checksum   <= checksum + word_data;
`endif
                    end
                end
                WRITE: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        wr_ptr     <= wr_ptr + ADDR_WIDTH'(4);
                        word_count <= word_count + ADDR_WIDTH'(1);
                        if (last_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ACCEPT;
                            word_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    word_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_adr   = {pc[ADDR_WIDTH-1:2], 2'b00};
    assign instruction = {mem[fetch_adr],
                          mem[fetch_adr + ADDR_WIDTH'(1)],
                          mem[fetch_adr + ADDR_WIDTH'(2)],
                          mem[fetch_adr + ADDR_WIDTH'(3)]};

    // Address bits outside the array and the sub-word bits are intentionally ignored.
    assign unused_addr_bits = ^{pc[31:ADDR_WIDTH], pc[1:0],
                                load_base_adr[31:ADDR_WIDTH], load_base_adr[1:0]};

endmodule
